// File: rtl/fp_pkg.sv
// Shared helpers for the parametrised sign/exponent/mantissa formats.
// Field helpers work on a 32-bit container, so operands must be at most 32 bits wide.
package fp_pkg;

    localparam int unsigned STICKY_IDX = 0;
    localparam int unsigned ROUND_IDX  = 1;
    localparam int unsigned GUARD_IDX  = 2;
    localparam int unsigned LSB_IDX    = 3;
    localparam int unsigned GRS_W      = 3;

    function automatic logic [31:0] fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic logic fp_sign(input logic [31:0] x, input int unsigned exp_w,
                                     input int unsigned man_w);
        return x[exp_w + man_w];
    endfunction

    function automatic logic [31:0] fp_exp(input logic [31:0] x, input int unsigned exp_w,
                                           input int unsigned man_w);
        return (x >> man_w) & ((32'd1 << exp_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fp_man(input logic [31:0] x, input int unsigned man_w);
        return x & ((32'd1 << man_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fp_max_mag(input int unsigned exp_w, input int unsigned man_w);
        return (32'd1 << (exp_w + man_w)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; count is WIDTH when the input is all zero.
module fp_lzc #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_comb begin
        count = CNT_W'(WIDTH);
        zero  = (value == '0);
        // Scanning upward lets the highest set bit win.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor (align, add/normalise, round/pack)
// with a valid/ready handshake; every stage advances together when en is high.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W = 4,
    parameter  int unsigned MAN_W = 3,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         ovf,
    output logic         inexact
);

    localparam int unsigned F       = MAN_W + 4;
    localparam int unsigned CW      = $clog2(F + 1);
    localparam int unsigned EMAX    = (1 << EXP_W) - 1;
    localparam logic [31:0] MAX_MAG = fp_max_mag(EXP_W, MAN_W);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: unpack, swap by magnitude, align operand 2 into hidden|man|G|R|S.
    logic [31:0]      a_w, b_w, p_w, q_w, e1_w, e2_w, m1_w, m2_w;
    logic             swap, h1, h2, al_sign, al_sub, stk;
    logic [EXP_W-1:0] e1, e2, d;
    logic [F-1:0]     al_m1, al_m2;

    always_comb begin
        a_w     = 32'(a);
        b_w     = 32'({b[W-1] ^ sub, b[W-2:0]});
        swap    = b_w[W-2:0] > a_w[W-2:0];
        p_w     = swap ? b_w : a_w;
        q_w     = swap ? a_w : b_w;
        e1_w    = fp_exp(p_w, EXP_W, MAN_W);
        e2_w    = fp_exp(q_w, EXP_W, MAN_W);
        m1_w    = fp_man(p_w, MAN_W);
        m2_w    = fp_man(q_w, MAN_W);
        h1      = |e1_w;
        h2      = |e2_w;
        e1      = h1 ? EXP_W'(e1_w) : EXP_W'(1);
        e2      = h2 ? EXP_W'(e2_w) : EXP_W'(1);
        d       = e1 - e2;
        al_sign = fp_sign(p_w, EXP_W, MAN_W);
        al_sub  = al_sign ^ fp_sign(q_w, EXP_W, MAN_W);
        al_m1   = F'(m1_w << GRS_W) | (F'(h1) << (F - 1));
        al_m2   = F'(m2_w << GRS_W) | (F'(h2) << (F - 1));
        stk     = 1'b0;
        for (int unsigned i = 0; i < F; i++) begin
            if (i < 32'(d)) begin
                stk   = stk | al_m2[STICKY_IDX];
                al_m2 = al_m2 >> 1;
            end
        end
        al_m2[STICKY_IDX] = al_m2[STICKY_IDX] | stk;
    end

    logic             s1_valid, s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [F-1:0]     s1_m1, s1_m2;

    // Stage 2: add/subtract, then normalise right on carry or left by the LZC.
    logic [F:0]     sum;
    logic [CW-1:0]  lz;
    logic           lz_zero, n_sign;
    logic [31:0]    lim, shamt;
    logic [F-1:0]   n_m;
    logic [EXP_W:0] n_exp;

    assign sum = s1_sub ? ({1'b0, s1_m1} - {1'b0, s1_m2}) : ({1'b0, s1_m1} + {1'b0, s1_m2});

    fp_lzc #(.WIDTH(F)) u_lzc (
        .value (sum[F-1:0]),
        .count (lz),
        .zero  (lz_zero)
    );

    always_comb begin
        n_sign = s1_sign;
        lim    = '0;
        shamt  = '0;
        if (sum[F]) begin
            n_m             = sum[F:1];
            n_m[STICKY_IDX] = sum[1] | sum[0];
            n_exp           = (EXP_W+1)'(32'(s1_exp) + 32'd1);
        end else begin
            lim   = 32'(s1_exp) - 32'd1;
            shamt = (32'(lz) < lim) ? 32'(lz) : lim;
            n_m   = sum[F-1:0] << shamt;
            n_exp = (EXP_W+1)'(32'(s1_exp) - shamt);
            if (!n_m[F-1]) n_exp = '0;
            // Cancellation to zero is +0; equal-sign zero sums keep their sign.
            if (lz_zero && s1_sub) n_sign = 1'b0;
        end
    end

    logic           s2_valid, s2_sign;
    logic [EXP_W:0] s2_exp;
    logic [F-1:0]   s2_m;

    // Stage 3: round to nearest even, renormalise a rounding carry, saturate.
    logic             g, r, s, up, sat;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   r_exp;
    logic [MAN_W-1:0] r_man;
    logic [W-1:0]     pk_c;

    always_comb begin
        g   = s2_m[GUARD_IDX];
        r   = s2_m[ROUND_IDX];
        s   = s2_m[STICKY_IDX];
        up  = g & (r | s | s2_m[LSB_IDX]);
        rnd = {1'b0, s2_m[F-1:LSB_IDX]} + (MAN_W+2)'(up);
        if (s2_exp == '0) begin
            r_exp = (EXP_W+1)'(rnd[MAN_W]);
            r_man = rnd[MAN_W-1:0];
        end else if (rnd[MAN_W+1]) begin
            r_exp = (EXP_W+1)'(32'(s2_exp) + 32'd1);
            r_man = '0;
        end else begin
            r_exp = s2_exp;
            r_man = rnd[MAN_W-1:0];
        end
        sat  = 32'(r_exp) > EMAX;
        pk_c = sat ? {s2_sign, (W-1)'(MAX_MAG)} : {s2_sign, r_exp[EXP_W-1:0], r_man};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
            inexact   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                c       <= pk_c;
                ovf     <= sat;
                inexact <= g | r | s | sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign <= al_sign;
            s1_sub  <= al_sub;
            s1_exp  <= e1;
            s1_m1   <= al_m1;
            s1_m2   <= al_m2;
            s2_sign <= n_sign;
            s2_exp  <= n_exp;
            s2_m    <= n_m;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: E4M3 and E5M2 instances share inputs and are checked
// against an exact-arithmetic rounding model (both formats are 8 bits wide).
module tb_fp_add_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, sub, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid, ovf, inexact;
    logic [7:0] c;
    logic       in_ready5, out_valid5, ovf5, inexact5;
    logic [7:0] c5;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(4), .MAN_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .ovf(ovf), .inexact(inexact)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid5), .out_ready(out_ready),
        .c(c5), .ovf(ovf5), .inexact(inexact5)
    );

    // Exact sum on a common integer scale, then round-to-nearest-even into the format.
    function automatic logic [7:0] ref_add(input int ew, input int mw, input logic [7:0] x,
                                           input logic [7:0] y, input logic s,
                                           output logic o_ovf, output logic o_inx);
        int     emax, exf, eyf, ex, ey, q, len, e, k;
        longint mx, my, sa, sb, sm, m, rem, half;
        logic   sx, sy, sg;
        emax  = (1 << ew) - 1;
        sx    = x[ew+mw];
        sy    = y[ew+mw] ^ s;
        exf   = int'(x >> mw) & emax;
        eyf   = int'(y >> mw) & emax;
        mx    = longint'(x) & ((longint'(1) << mw) - 1);
        my    = longint'(y) & ((longint'(1) << mw) - 1);
        ex    = (exf == 0) ? 1 : exf;
        ey    = (eyf == 0) ? 1 : eyf;
        if (exf != 0) mx = mx + (longint'(1) << mw);
        if (eyf != 0) my = my + (longint'(1) << mw);
        q     = (ex < ey) ? ex : ey;
        sa    = mx << (ex - q);
        sb    = my << (ey - q);
        if (sx) sa = -sa;
        if (sy) sb = -sb;
        sm    = sa + sb;
        o_ovf = 1'b0;
        o_inx = 1'b0;
        if (sm == 0) return {sx & sy, 7'h00};
        sg = (sm < 0);
        if (sg) sm = -sm;
        len = 0;
        while ((sm >> len) != 0) len++;
        e = q + len - mw - 1;
        if (e < 1) e = 1;
        if (e <= q) begin
            m = sm << (q - e);
        end else begin
            k     = e - q;
            m     = sm >> k;
            rem   = sm & ((longint'(1) << k) - 1);
            half  = longint'(1) << (k - 1);
            o_inx = (rem != 0);
            if (rem > half || (rem == half && m[0])) m = m + 1;
        end
        if (m == (longint'(1) << (mw + 1))) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e > emax) begin
            o_ovf = 1'b1;
            o_inx = 1'b1;
            return {sg, 7'h7F};
        end
        if (m < (longint'(1) << mw)) e = 0;
        return {sg, 7'((longint'(e) << mw) | (m & ((longint'(1) << mw) - 1)))};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, c, ovf, inexact} !== 11'h0)
            begin miscompares++; $display("FAIL reset_e4m3: got v=%b c=%h o=%b i=%b want all 0", out_valid, c, ovf, inexact); end
        vectors++;
        if ({out_valid5, c5, ovf5, inexact5} !== 11'h0)
            begin miscompares++; $display("FAIL reset_e5m2: got v=%b c=%h o=%b i=%b want all 0", out_valid5, c5, ovf5, inexact5); end
        vectors++;
        if (in_ready !== 1'b1)
            begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta   [10] = '{8'h38, 8'h38, 8'hB8, 8'h80, 8'h38, 8'h39, 8'h01, 8'h07, 8'h7F, 8'hFF};
        logic [7:0] tbv  [10] = '{8'h38, 8'h38, 8'hB8, 8'h80, 8'h18, 8'h18, 8'h01, 8'h01, 8'h7F, 8'hFF};
        logic       ts   [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] tc   [10] = '{8'h40, 8'h00, 8'hC0, 8'h80, 8'h38, 8'h3A, 8'h02, 8'h08, 8'h7F, 8'hFF};
        logic       tovf [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       tinx [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] r5;
        logic       o5, i5;
        int         lat;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = ta[i]; b = tbv[i]; sub = ts[i]; in_valid = 1'b1; out_ready = 1'b1;
            r5  = ref_add(5, 2, ta[i], tbv[i], ts[i], o5, i5);
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
            end while (out_valid !== 1'b1 && lat < 8);
            vectors++;
            if (lat != 3)
                begin miscompares++; $display("FAIL latency[%0d]: got %0d cycles want 3", i, lat); end
            vectors++;
            if ({ovf, inexact, c} !== {tovf[i], tinx[i], tc[i]})
                begin miscompares++; $display("FAIL directed[%0d] %h%s%h: got c=%h o=%b i=%b want c=%h o=%b i=%b", i, ta[i], ts[i] ? "-" : "+", tbv[i], c, ovf, inexact, tc[i], tovf[i], tinx[i]); end
            vectors++;
            if (out_valid5 !== 1'b1 || {ovf5, inexact5, c5} !== {o5, i5, r5})
                begin miscompares++; $display("FAIL directed_e5m2[%0d]: got v=%b c=%h o=%b i=%b want v=1 c=%h o=%b i=%b", i, out_valid5, c5, ovf5, inexact5, r5, o5, i5); end
        end
    endtask

    // Random operand stream with random gaps and out_ready stalls, scoreboarded in order.
    task automatic run_stream(input int n, input int stall_pct, input string tag);
        logic [9:0] q4[$], q5[$];
        logic [9:0] exp_v, h4, h5;
        logic [7:0] r;
        logic       o, ix, hv4, hv5, acc;
        int         sent, got, cyc;
        sent = 0; got = 0; cyc = 0; hv4 = 1'b0; hv5 = 1'b0; acc = 1'b0; h4 = '0; h5 = '0;
        in_valid = 1'b0;
        while (got < n && cyc < n * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (acc) begin in_valid = 1'b0; acc = 1'b0; end
            if (!in_valid && sent < n && (stall_pct == 0 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            #1;
            if (hv4) begin
                vectors++;
                if (out_valid !== 1'b1 || {ovf, inexact, c} !== h4)
                    begin miscompares++; $display("FAIL %s hold_e4m3: got v=%b {o,i,c}=%h want v=1 %h", tag, out_valid, {ovf, inexact, c}, h4); end
            end
            if (hv5) begin
                vectors++;
                if (out_valid5 !== 1'b1 || {ovf5, inexact5, c5} !== h5)
                    begin miscompares++; $display("FAIL %s hold_e5m2: got v=%b {o,i,c}=%h want v=1 %h", tag, out_valid5, {ovf5, inexact5, c5}, h5); end
            end
            if (stall_pct == 0 && in_valid) begin
                vectors++;
                if (in_ready !== 1'b1)
                    begin miscompares++; $display("FAIL %s full_rate: got in_ready=%b want 1", tag, in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (q4.size() == 0) begin
                    miscompares++; $display("FAIL %s spurious_e4m3: got c=%h want no result", tag, c);
                end else begin
                    exp_v = q4.pop_front();
                    if ({ovf, inexact, c} !== exp_v)
                        begin miscompares++; $display("FAIL %s result_e4m3: got {o,i,c}=%h want %h", tag, {ovf, inexact, c}, exp_v); end
                end
                got++;
            end
            if (out_valid5 === 1'b1 && out_ready) begin
                vectors++;
                if (q5.size() == 0) begin
                    miscompares++; $display("FAIL %s spurious_e5m2: got c=%h want no result", tag, c5);
                end else begin
                    exp_v = q5.pop_front();
                    if ({ovf5, inexact5, c5} !== exp_v)
                        begin miscompares++; $display("FAIL %s result_e5m2: got {o,i,c}=%h want %h", tag, {ovf5, inexact5, c5}, exp_v); end
                end
            end
            hv4 = out_valid && !out_ready; h4 = {ovf, inexact, c};
            hv5 = out_valid5 && !out_ready; h5 = {ovf5, inexact5, c5};
            if (in_valid && in_ready) begin
                r = ref_add(4, 3, a, b, sub, o, ix);
                q4.push_back({o, ix, r});
                sent++;
                acc = 1'b1;
            end
            if (in_valid && in_ready5) begin
                r = ref_add(5, 2, a, b, sub, o, ix);
                q5.push_back({o, ix, r});
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (got != n || q5.size() != 0)
            begin miscompares++; $display("FAIL %s count: got %0d results (%0d e5m2 left) want %0d (0 left)", tag, got, q5.size(), n); end
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || out_valid5 !== 1'b0)
                begin miscompares++; $display("FAIL %s drain: got out_valid=%b/%b want 0/0", tag, out_valid, out_valid5); end
        end
    endtask

    task automatic test_backpressure();
        run_stream(8, 50, "backpressure");
    endtask

    task automatic test_back_to_back();
        run_stream(200, 0, "back_to_back");
    endtask

    task automatic test_random_stall();
        run_stream(150, 30, "random_stall");
    endtask

    task automatic test_reset_midflight();
        int lat;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1)
            begin miscompares++; $display("FAIL midflight_stalled: got out_valid=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, c, ovf, inexact} !== 11'h0 || out_valid5 !== 1'b0)
            begin miscompares++; $display("FAIL midflight_reset: got v=%b c=%h o=%b i=%b v5=%b want all 0", out_valid, c, ovf, inexact, out_valid5); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        a = 8'h39; b = 8'h18; sub = 1'b0; in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 8);
        vectors++;
        if (lat != 3 || {ovf, inexact, c} !== {1'b0, 1'b1, 8'h3A})
            begin miscompares++; $display("FAIL post_reset_first: got lat=%0d c=%h o=%b i=%b want lat=3 c=3a o=0 i=1", lat, c, ovf, inexact); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
